fifo_ram: RTL and testbench

Dual-port RAM for a simple FIFO: one synchronous write port and one synchronous read port, each with an independent address. The parent FIFO controller (trace buffers, NoC input-port flit buffers) supplies the pointers and keeps the occupancy count. Sized to infer a single FPGA block RAM. An optional same-address bypass supports single-cycle bypass operation in the NoC buffers.

---
 rtl/fifo_ram.sv | 59 +++++
 tb/tb_fifo_ram.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - dual-port FIFO storage RAM, one write port and one registered read port
// Define FIFO_RAM_DUMP_EN to print accepted writes and reads in simulation.
module fifo_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 9,
    parameter string SSA_EN     = "NO"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int   DEPTH  = 1 << ADDR_WIDTH;
    localparam logic BYPASS = (SSA_EN == "YES");

    // Power-up zero contents; the array has no reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic collide;
    assign collide = wr_en && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Without bypass the read sees the pre-write contents on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (BYPASS && collide) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

`ifdef FIFO_RAM_DUMP_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                $display("fifo_ram wr addr=%h data=%h", wr_addr, wr_data);
            end
            if (rd_en) begin
                $display("fifo_ram rd addr=%h", rd_addr);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ram.sv
// tb/tb_fifo_ram.sv - directed vector bench for fifo_ram, read-first and bypass instances side by side
module tb_fifo_ram;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data_no;
    logic [DW-1:0] rd_data_yes;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SSA_EN("NO")) dut_no (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_no)
    );

    fifo_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SSA_EN("YES")) dut_yes (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_en(wr_en), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_yes)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_no;
        logic [DW-1:0] exp_yes;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 9'd3,   32'hDEADBEEF, 1'b0, 9'd0,   32'h0,        32'h0};
        vecs[1]  = '{1'b0, 9'd0,   32'h0,        1'b1, 9'd3,   32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 9'd3,   32'h12345678, 1'b0, 9'd3,   32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 9'd0,   32'h0,        1'b1, 9'd3,   32'h12345678, 32'h12345678};
        vecs[4]  = '{1'b1, 9'd5,   32'h11111111, 1'b0, 9'd0,   32'h12345678, 32'h12345678};
        vecs[5]  = '{1'b1, 9'd5,   32'h22222222, 1'b1, 9'd5,   32'h11111111, 32'h22222222};
        vecs[6]  = '{1'b0, 9'd0,   32'h0,        1'b1, 9'd5,   32'h22222222, 32'h22222222};
        vecs[7]  = '{1'b1, 9'd7,   32'hAAAA5555, 1'b1, 9'd3,   32'h12345678, 32'h12345678};
        vecs[8]  = '{1'b0, 9'd0,   32'h0,        1'b1, 9'd7,   32'hAAAA5555, 32'hAAAA5555};
        vecs[9]  = '{1'b0, 9'd0,   32'h0,        1'b1, 9'd100, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 9'd3,   32'hDEADBEEF, 1'b1, 9'd3,   32'h12345678, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 9'd0,   32'h0,        1'b1, 9'd3,   32'hDEADBEEF, 32'hDEADBEEF};

        // Reset state, with strobes active to show they are ignored.
        drive(1'b1, 9'd3, 32'hFFFFFFFF, 1'b1, 9'd3);
        tick();
        tick();
        chk("reset_no", rd_data_no, 32'h0);
        chk("reset_yes", rd_data_yes, 32'h0);
        drive(1'b0, 9'd0, 32'h0, 1'b0, 9'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd3);
        tick();
        chk("reset_wr_ignored_no", rd_data_no, 32'h0);
        chk("reset_wr_ignored_yes", rd_data_yes, 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
            tick();
            chk($sformatf("vec%0d_no", i), rd_data_no, vecs[i].exp_no);
            chk($sformatf("vec%0d_yes", i), rd_data_yes, vecs[i].exp_yes);
        end

        // Fill the whole array with a wrapping pointer, then overwrite address 0.
        begin
            logic [AW-1:0] ptr;
            ptr = '0;
            for (int i = 0; i < 512; i++) begin
                drive(1'b1, ptr, DW'(i), 1'b0, 9'd0);
                tick();
                ptr = ptr + 1'b1;
            end
            drive(1'b1, ptr, 32'h0000AAAA, 1'b0, 9'd0);
            tick();
            for (int i = 0; i < 512; i++) begin
                logic [DW-1:0] exp;
                exp = (i == 0) ? 32'h0000AAAA : DW'(i);
                drive(1'b0, 9'd0, 32'h0, 1'b1, AW'(i));
                tick();
                chk($sformatf("fill%0d_no", i), rd_data_no, exp);
                chk($sformatf("fill%0d_yes", i), rd_data_yes, exp);
            end
        end

        // Asynchronous reset in mid-cycle with memory preserved.
        drive(1'b1, 9'd3, 32'hDEADBEEF, 1'b0, 9'd0);
        tick();
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd3);
        tick();
        chk("pre_reset_no", rd_data_no, 32'hDEADBEEF);
        chk("pre_reset_yes", rd_data_yes, 32'hDEADBEEF);
        drive(1'b1, 9'd3, 32'h0BADF00D, 1'b1, 9'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_no", rd_data_no, 32'h0);
        chk("async_reset_yes", rd_data_yes, 32'h0);
        tick();
        tick();
        chk("reset_hold_no", rd_data_no, 32'h0);
        chk("reset_hold_yes", rd_data_yes, 32'h0);
        drive(1'b0, 9'd0, 32'h0, 1'b1, 9'd3);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_reset_no", rd_data_no, 32'hDEADBEEF);
        chk("post_reset_yes", rd_data_yes, 32'hDEADBEEF);
        drive(1'b0, 9'd0, 32'h0, 1'b0, 9'd0);
        tick();
        chk("post_reset_hold_no", rd_data_no, 32'hDEADBEEF);
        chk("post_reset_hold_yes", rd_data_yes, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
